// File: rtl/fifo_wr_ptr_ctrl_if.sv
// rtl/fifo_wr_ptr_ctrl_if.sv - producer/RAM/read-pointer signal bundle for the FIFO write-side controller
interface fifo_wr_ptr_ctrl_if #(
  parameter int ADDR_W = 3
);
  logic              wr_req;
  logic              clr_ovf;
  logic [ADDR_W:0]   rd_ptr_gray;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   wr_ptr_gray;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   level;
  logic              overflow;

  modport master (
    output wr_req, clr_ovf, rd_ptr_gray,
    input  wr_en, wr_addr, wr_ptr_gray, full, almost_full, level, overflow
  );

  modport slave (
    input  wr_req, clr_ovf, rd_ptr_gray,
    output wr_en, wr_addr, wr_ptr_gray, full, almost_full, level, overflow
  );
endinterface

// File: rtl/fifo_wr_ptr_ctrl.sv
// rtl/fifo_wr_ptr_ctrl.sv - async FIFO write pointer/flag controller; FIFO_WR_PTR_SYNC_EN adds a 2-flop read-pointer synchroniser
module fifo_wr_ptr_ctrl #(
  parameter int ADDR_W       = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic              i_clk,
  input  logic              i_reset,
  fifo_wr_ptr_ctrl_if.slave bus
);
  localparam int            PW        = ADDR_W + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  if (ADDR_W < 2 || AFULL_THRESH < 1 || AFULL_THRESH > (1 << ADDR_W)) begin : g_param_err
    $error("fifo_wr_ptr_ctrl: ADDR_W must be >= 2 and AFULL_THRESH within 1..2**ADDR_W");
  end

  logic [PW-1:0] r_wr_bin;
  logic [PW-1:0] r_wr_gray;
  logic [PW-1:0] r_level;
  logic          r_full;
  logic          r_afull;
  logic          r_ovf;

  logic [PW-1:0] w_rd_s;
  logic [PW-1:0] w_rd_bin;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_gray_next;
  logic [PW-1:0] w_level_next;
  logic          w_wr_en;
  logic          w_full_next;
  logic          w_afull_next;
  logic          w_ovf_next;

`ifdef FIFO_WR_PTR_SYNC_EN
  logic [PW-1:0] r_rd_sync1;
  logic [PW-1:0] r_rd_sync2;

  // Bring the read-domain Gray pointer into clk through two flops
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_sync1 <= '0;
      r_rd_sync2 <= '0;
    end else begin
      r_rd_sync1 <= bus.rd_ptr_gray;
      r_rd_sync2 <= r_rd_sync1;
    end
  end

  assign w_rd_s = r_rd_sync2;
`else
  assign w_rd_s = bus.rd_ptr_gray;
`endif

  // Next pointer, occupancy and flag values; full compares against the read
  // pointer with its top two Gray bits inverted (one lap ahead)
  always_comb begin
    w_wr_en     = bus.wr_req & ~r_full;
    w_bin_next  = r_wr_bin + {{ADDR_W{1'b0}}, w_wr_en};
    w_gray_next = w_bin_next ^ (w_bin_next >> 1);
    w_rd_bin    = '0;
    for (int i = 0; i < PW; i++) begin
      w_rd_bin[i] = ^(w_rd_s >> i);
    end
    w_full_next  = (w_gray_next == {~w_rd_s[PW-1:PW-2], w_rd_s[PW-3:0]});
    w_level_next = w_bin_next - w_rd_bin;
    w_afull_next = (w_level_next >= AFULL_LVL);
    w_ovf_next   = r_ovf;
    if (bus.wr_req & r_full) begin
      w_ovf_next = 1'b1;
    end else if (bus.clr_ovf) begin
      w_ovf_next = 1'b0;
    end
  end

  // Pointer and flag registers; Gray pointer leaves straight from its flop
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_bin  <= '0;
      r_wr_gray <= '0;
      r_level   <= '0;
      r_full    <= 1'b0;
      r_afull   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_wr_bin  <= w_bin_next;
      r_wr_gray <= w_gray_next;
      r_level   <= w_level_next;
      r_full    <= w_full_next;
      r_afull   <= w_afull_next;
      r_ovf     <= w_ovf_next;
    end
  end

  assign bus.wr_en       = w_wr_en;
  assign bus.wr_addr     = r_wr_bin[ADDR_W-1:0];
  assign bus.wr_ptr_gray = r_wr_gray;
  assign bus.full        = r_full;
  assign bus.almost_full = r_afull;
  assign bus.level       = r_level;
  assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// tb/tb_fifo_wr_ptr_ctrl.sv - scoreboard testbench for fifo_wr_ptr_ctrl
module tb_fifo_wr_ptr_ctrl;
  localparam int AW = 3;
`ifdef FIFO_WR_PTR_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_ptr_ctrl_if #(.ADDR_W(AW)) bus ();

  fifo_wr_ptr_ctrl #(.ADDR_W(AW), .AFULL_THRESH(6)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  typedef struct {
    bit wr_en;
    int addr;
    int gray;
    bit full;
    bit afull;
    int level;
    bit ovf;
    bit hg_en;
    int hg;
    bit hf_en;
    bit hf;
    bit after_rst;
    int tid;
  } exp_t;

  exp_t q[$];
  exp_t me;

  int n_vec = 0;
  int n_err = 0;
  int cur_tid = 0;

  int m_bin, m_level, m_s1, m_s2;
  bit m_full, m_afull, m_ovf;
  bit last_rst;

  logic [3:0] prev_g;
  bit prev_v = 1'b0;
  bit saw_wrap = 1'b0;

  int t1_g[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  function automatic int gray4(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  task automatic chk(input string nm, input int tid, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL t%0d %s: got %0d expected %0d", tid, nm, act, exp);
    end
  endtask

  // One stimulus cycle: drive inputs, push the outputs expected in this cycle,
  // then advance the reference occupancy model across the coming edge
  task automatic cyc(input bit wr, input bit clr, input bit rst, input int rdb,
                     input bit hg_en = 1'b0, input int hg = 0,
                     input bit hf_en = 1'b0, input bit hf = 1'b0);
    exp_t e;
    int   rds;
    bit   we;
    bit   old_full;
    @(posedge clk);
    #1;
    bus.wr_req      = wr;
    bus.clr_ovf     = clr;
    reset           = rst;
    bus.rd_ptr_gray = 4'(gray4(rdb & 15));
    old_full = m_full;
    we = wr && !old_full;
    e.wr_en = we;      e.addr = m_bin & 7;  e.gray = gray4(m_bin);
    e.full = m_full;   e.afull = m_afull;   e.level = m_level;  e.ovf = m_ovf;
    e.hg_en = hg_en;   e.hg = hg;           e.hf_en = hf_en;    e.hf = hf;
    e.after_rst = last_rst;
    e.tid = cur_tid;
    q.push_back(e);
    rds = SYNC ? m_s2 : (rdb & 15);
    if (rst) begin
      m_bin = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      if (we) m_bin = (m_bin + 1) & 15;
      m_level = (m_bin - rds) & 15;
      m_full  = (m_level == 8);
      m_afull = (m_level >= 6);
      if (wr && old_full) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_s2 = m_s1;
      m_s1 = rdb & 15;
    end
    last_rst = rst;
  endtask

  // Monitor: the DUT presents a settled output set every cycle; compare it
  // against the oldest queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("wr_en",       me.tid, bus.wr_en,       me.wr_en);
      chk("wr_addr",     me.tid, bus.wr_addr,     me.addr);
      chk("wr_ptr_gray", me.tid, bus.wr_ptr_gray, me.gray);
      chk("full",        me.tid, bus.full,        me.full);
      chk("almost_full", me.tid, bus.almost_full, me.afull);
      chk("level",       me.tid, bus.level,       me.level);
      chk("overflow",    me.tid, bus.overflow,    me.ovf);
      if (me.hg_en) chk("gray_table", me.tid, bus.wr_ptr_gray, me.hg);
      if (me.hf_en) chk("full_timing", me.tid, bus.full, me.hf);
      if (prev_v && !me.after_rst && bus.wr_ptr_gray != prev_g) begin
        chk("gray_onebit", me.tid, $countones(bus.wr_ptr_gray ^ prev_g), 1);
        if (prev_g == 4'h8 && bus.wr_ptr_gray == 4'h0) saw_wrap = 1'b1;
      end
      prev_g = bus.wr_ptr_gray;
      prev_v = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000ns, expected finish");
    $fatal(1);
  end

  initial begin
    bus.wr_req = 1'b0; bus.clr_ovf = 1'b0; bus.rd_ptr_gray = '0; reset = 1'b1;
    m_bin = 0; m_level = 0; m_s1 = 0; m_s2 = 0;
    m_full = 0; m_afull = 0; m_ovf = 0; last_rst = 1'b1;
    repeat (3) @(posedge clk);

    // T1 fill from empty with the read pointer parked at 0
    cur_tid = 1;
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 1, t1_g[i]);

    // T2 blocked writes, sticky overflow, clear, and set-beats-clear
    cur_tid = 2;
    cyc(1, 0, 0, 0, 1, 'hC, 1, 1);
    cyc(1, 0, 0, 0, 1, 'hC, 1, 1);
    cyc(0, 0, 0, 0, 1, 'hC);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // T3 reader trails the writer by four through a pointer wrap
    cur_tid = 3;
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, m_bin - 4);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, m_bin - 4);

    // T4 almost_full threshold crossing and release after a read advance
    cur_tid = 4;
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 2);

    // T5 reset in the middle of traffic with a write pending
    cur_tid = 5;
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0);

    // T6 full release latency after a one-entry read advance
    cur_tid = 6;
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0, 0, 1, SYNC);
    cyc(0, 0, 0, 1, 0, 0, 1, SYNC);
    cyc(0, 0, 0, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drain", 0, q.size(), 0);
    chk("gray_wrap_8_to_0", 3, saw_wrap, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
